pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer.
// It steps the CPU fetch address from the datapath's next-address candidate
// and holds that address while the current instruction is stalled.
// It halts on a self-loop or on an illegal target, and counts retired
// instructions. Leaving HALT requires Restart.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IM_BYTES     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] NextAddr,
    input  logic        Stall,
    input  logic        Restart,
    output logic [31:0] PC,
    output logic        PCValid,
    output logic        Halted,
    output logic        Fault,
    output logic [1:0]  State,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Highest word-aligned address that still lies inside instruction memory.
    localparam logic [31:0] IM_LAST = 32'(IM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        pcvalid_q;
    logic        halted_q;

    // A target is illegal when it is misaligned or beyond the last word.
    function automatic logic addr_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > IM_LAST);
    endfunction

    // The retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
    endfunction

    // State register with asynchronous reset. PCValid and Halted are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_VECTOR;
            cnt_q     <= 32'd0;
            fault_q   <= 1'b0;
            pcvalid_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            pcvalid_q <= (state_d == ST_RUN) || (state_d == ST_STALL);
            halted_q  <= (state_d == ST_HALT);
        end
    end

    // Next-state logic. A commit checks for an illegal target first, then a self-loop, then takes a normal step.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (Stall) begin
                    state_d = ST_STALL;
                end else if (addr_illegal(NextAddr)) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                    cnt_d   = sat_inc(cnt_q);
                end else if (NextAddr == pc_q) begin
                    state_d = ST_HALT;
                    cnt_d   = sat_inc(cnt_q);
                end else begin
                    state_d = ST_RUN;
                    pc_d    = NextAddr;
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            ST_HALT: begin
                if (Restart) begin
                    state_d = ST_IDLE;
                    pc_d    = RESET_VECTOR;
                    cnt_d   = 32'd0;
                    fault_d = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_VECTOR;
                cnt_d   = 32'd0;
                fault_d = 1'b0;
            end
        endcase
    end

    assign PC         = pc_q;
    assign State      = state_q;
    assign InstrCount = cnt_q;
    assign Fault      = fault_q;
    assign PCValid    = pcvalid_q;
    assign Halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (RESET_VECTOR=0, IM_BYTES=1024).
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] NextAddr;
    logic        Stall;
    logic        Restart;
    logic [31:0] PC;
    logic        PCValid;
    logic        Halted;
    logic        Fault;
    logic [1:0]  State;
    logic [31:0] InstrCount;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STALL = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .IM_BYTES    (1024)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .NextAddr  (NextAddr),
        .Stall     (Stall),
        .Restart   (Restart),
        .PC        (PC),
        .PCValid   (PCValid),
        .Halted    (Halted),
        .Fault     (Fault),
        .State     (State),
        .InstrCount(InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] na;
        logic        stall;
        logic        restart;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        valid;
        logic        halted;
        logic        fault;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic [31:0] na, input logic stall, input logic restart,
                                input logic [31:0] pc, input logic [1:0] st, input logic [31:0] cnt,
                                input logic fault);
        vec_t v;
        v.na      = na;
        v.stall   = stall;
        v.restart = restart;
        v.pc      = pc;
        v.st      = st;
        v.cnt     = cnt;
        v.valid   = (st == S_RUN) || (st == S_STALL);
        v.halted  = (st == S_HALT);
        v.fault   = fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [1:0] st,
                           input logic [31:0] cnt, input logic valid, input logic halted,
                           input logic fault);
        chk({tag, ".PC"},         PC,                 pc);
        chk({tag, ".State"},      {30'd0, State},     {30'd0, st});
        chk({tag, ".InstrCount"}, InstrCount,         cnt);
        chk({tag, ".PCValid"},    {31'd0, PCValid},   {31'd0, valid});
        chk({tag, ".Halted"},     {31'd0, Halted},    {31'd0, halted});
        chk({tag, ".Fault"},      {31'd0, Fault},     {31'd0, fault});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Normal flow: 0,0,4,8,12, then a self-loop halt at 16.
        vecs[0]  = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_RUN,   32'd0, 1'b0);
        vecs[1]  = mk(32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, S_RUN,   32'd1, 1'b0);
        vecs[2]  = mk(32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008, S_RUN,   32'd2, 1'b0);
        vecs[3]  = mk(32'h0000_000C, 1'b0, 1'b0, 32'h0000_000C, S_RUN,   32'd3, 1'b0);
        vecs[4]  = mk(32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, S_RUN,   32'd4, 1'b0);
        vecs[5]  = mk(32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, S_HALT,  32'd5, 1'b0);
        // HALT ignores NextAddr and Stall; Restart goes to IDLE.
        vecs[6]  = mk(32'h0000_0014, 1'b1, 1'b0, 32'h0000_0010, S_HALT,  32'd5, 1'b0);
        vecs[7]  = mk(32'h0000_0014, 1'b0, 1'b1, 32'h0000_0000, S_IDLE,  32'd0, 1'b0);
        // IDLE ignores NextAddr; then a stall at PC=8.
        vecs[8]  = mk(32'h0000_0064, 1'b0, 1'b0, 32'h0000_0000, S_RUN,   32'd0, 1'b0);
        vecs[9]  = mk(32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, S_RUN,   32'd1, 1'b0);
        vecs[10] = mk(32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008, S_RUN,   32'd2, 1'b0);
        vecs[11] = mk(32'h0000_000C, 1'b1, 1'b0, 32'h0000_0008, S_STALL, 32'd2, 1'b0);
        vecs[12] = mk(32'h0000_000C, 1'b1, 1'b0, 32'h0000_0008, S_STALL, 32'd2, 1'b0);
        vecs[13] = mk(32'h0000_000C, 1'b0, 1'b0, 32'h0000_000C, S_RUN,   32'd3, 1'b0);
        // Misaligned target while Restart is high (ignored in RUN).
        vecs[14] = mk(32'h0000_0402, 1'b0, 1'b1, 32'h0000_000C, S_HALT,  32'd4, 1'b1);
        vecs[15] = mk(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, S_IDLE,  32'd0, 1'b0);
        vecs[16] = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_RUN,   32'd0, 1'b0);
        // Out-of-range target.
        vecs[17] = mk(32'h0000_0400, 1'b0, 1'b0, 32'h0000_0000, S_HALT,  32'd1, 1'b1);
        vecs[18] = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_HALT,  32'd1, 1'b1);
        vecs[19] = mk(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, S_IDLE,  32'd0, 1'b0);
        vecs[20] = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_RUN,   32'd0, 1'b0);
        // Self-loop at the reset vector.
        vecs[21] = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_HALT,  32'd1, 1'b0);
        vecs[22] = mk(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, S_IDLE,  32'd0, 1'b0);
        vecs[23] = mk(32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, S_RUN,   32'd0, 1'b0);
        // The last legal word is accepted, and a misaligned neighbour faults.
        vecs[24] = mk(32'h0000_03FC, 1'b0, 1'b0, 32'h0000_03FC, S_RUN,   32'd1, 1'b0);
        vecs[25] = mk(32'h0000_03FD, 1'b0, 1'b0, 32'h0000_03FC, S_HALT,  32'd2, 1'b1);

        rst_n    = 1'b0;
        NextAddr = 32'd0;
        Stall    = 1'b0;
        Restart  = 1'b0;
        #12;
        chk_all("reset", 32'h0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);
        // Release reset between clock edges.
        #5;
        rst_n = 1'b1;
        chk_all("idle", 32'h0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 26; i++) begin
            NextAddr = vecs[i].na;
            Stall    = vecs[i].stall;
            Restart  = vecs[i].restart;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].st, vecs[i].cnt,
                    vecs[i].valid, vecs[i].halted, vecs[i].fault);
        end

        // Asynchronous reset asserted mid-STALL, checked before the next edge.
        Restart = 1'b1;
        Stall   = 1'b0;
        step();
        Restart = 1'b0;
        step();
        NextAddr = 32'h0000_0008;
        step();
        NextAddr = 32'h0000_000C;
        Stall    = 1'b1;
        step();
        chk_all("pre_rst_stall", 32'h8, S_STALL, 32'd1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst_stall", 32'h0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_held", 32'h0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        Stall = 1'b0;
        step();
        chk_all("post_rst_run", 32'h0, S_RUN, 32'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset asserted during a faulted HALT.
        NextAddr = 32'h0000_0401;
        step();
        chk_all("pre_rst_halt", 32'h0, S_HALT, 32'd1, 1'b0, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst_halt", 32'h0, S_IDLE, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk_all("post_rst_halt", 32'h0, S_RUN, 32'd0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
